// File: rtl/regfile_pkg.sv
// Shared sizing and state encoding for the integer register file.
// The default widths can be overridden by predefining REG_ADDR_SIZE / REG_DATA_SIZE.
`ifndef REG_ADDR_SIZE
`define REG_ADDR_SIZE 4
`endif
`ifndef REG_DATA_SIZE
`define REG_DATA_SIZE 31
`endif
`ifndef RF_ST_INIT
`define RF_ST_INIT 1'b0
`endif
`ifndef RF_ST_RUN
`define RF_ST_RUN 1'b1
`endif

package regfile_pkg;

  localparam int ADDR_W   = `REG_ADDR_SIZE + 1;
  localparam int DATA_W   = `REG_DATA_SIZE + 1;
  localparam int NUM_REGS = 2 ** ADDR_W;

  localparam logic [ADDR_W-1:0] FIRST_REG = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] LAST_REG  = ADDR_W'(NUM_REGS - 1);

  typedef enum logic {
    RF_ST_INIT = `RF_ST_INIT,
    RF_ST_RUN  = `RF_ST_RUN
  } rf_state_e;

endpackage

// File: rtl/regfile_init_ctrl.sv
// Post-reset init sequencer: walks x1..x31 clearing one register per cycle,
// then raises ready and stays in RUN until the next reset.
module regfile_init_ctrl
  import regfile_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  output logic              clr_en,
  output logic [ADDR_W-1:0] clr_addr,
  output logic              ready
);

  rf_state_e         state;
  logic [ADDR_W-1:0] init_ptr;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= RF_ST_INIT;
      init_ptr <= FIRST_REG;
      ready    <= 1'b0;
    end else begin
      case (state)
        RF_ST_INIT: begin
          init_ptr <= init_ptr + ADDR_W'(1);
          if (init_ptr == LAST_REG) begin
            state <= RF_ST_RUN;
            ready <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // A reset edge must leave the array untouched, so the clear is masked by reset.
  assign clr_en   = (state == RF_ST_INIT) && !reset;
  assign clr_addr = init_ptr;

endmodule

// File: rtl/regfile.sv
// Integer register file: writeback write port, two combinational decode read ports.
// REGFILE_BYPASS_EN forwards a same-cycle write to matching read ports; SIMULATE logs commits.
module regfile
  import regfile_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_enable,
  input  logic [ADDR_W-1:0] rs1_addr,
  output logic [DATA_W-1:0] rs1_data,
  input  logic [ADDR_W-1:0] rs2_addr,
  output logic [DATA_W-1:0] rs2_data,
  output logic              ready
);

  logic              clr_en;
  logic [ADDR_W-1:0] clr_addr;
  logic              wr_commit;
  logic [DATA_W-1:0] mem [1:NUM_REGS-1];

  regfile_init_ctrl u_init_ctrl (
    .clk      (clk),
    .reset    (reset),
    .clr_en   (clr_en),
    .clr_addr (clr_addr),
    .ready    (ready)
  );

  // ready doubles as "in RUN"; writes outside RUN are dropped, not queued.
  assign wr_commit = ready && !reset && wr_enable && (wr_addr != '0);

  always_ff @(posedge clk) begin
    if (clr_en) begin
      mem[clr_addr] <= '0;
    end else if (wr_commit) begin
      mem[wr_addr] <= wr_data;
`ifdef SIMULATE
      $display("REGFILE: r%0d <= %h", wr_addr, wr_data);
`endif
    end
  end

  function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
    logic [DATA_W-1:0] value;
    value = '0;
    if (ready && (addr != '0)) begin
      value = mem[addr];
`ifdef REGFILE_BYPASS_EN
      if (wr_commit && (addr == wr_addr)) begin
        value = wr_data;
      end
`endif
    end
    return value;
  endfunction

  always_comb begin
    rs1_data = read_port(rs1_addr);
    rs2_data = read_port(rs2_addr);
  end

endmodule

// File: tb/tb_regfile.sv
// Randomized self-checking bench for regfile against an array-based reference model.
// Honours REGFILE_BYPASS_EN in the model's same-cycle read expectation.
module tb_regfile;
  import regfile_pkg::*;

  logic              clk;
  logic              reset;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_enable;
  logic [ADDR_W-1:0] rs1_addr;
  logic [DATA_W-1:0] rs1_data;
  logic [ADDR_W-1:0] rs2_addr;
  logic [DATA_W-1:0] rs2_data;
  logic              ready;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model: architectural contents, ready flag, count of clears done.
  logic [DATA_W-1:0] model_regs [NUM_REGS];
  bit                model_ready;
  int                model_cleared;

  logic [DATA_W-1:0] obs_rs1;
  logic [DATA_W-1:0] obs_rs2;
  logic              obs_ready;

  regfile dut (
    .clk       (clk),
    .reset     (reset),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_enable (wr_enable),
    .rs1_addr  (rs1_addr),
    .rs1_data  (rs1_data),
    .rs2_addr  (rs2_addr),
    .rs2_data  (rs2_data),
    .ready     (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [DATA_W-1:0] observed,
                             input logic [DATA_W-1:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  function automatic logic [DATA_W-1:0] modelRead(input int addr, input bit rst, input bit we,
                                                  input int wa, input logic [DATA_W-1:0] wd);
    if (!model_ready || addr == 0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (!rst && we && wa != 0 && wa == addr) return wd;
`endif
    return model_regs[addr];
  endfunction

  // Drive one cycle of inputs, check outputs mid-cycle, then advance the model at the edge.
  task automatic applyStimulus(input string tag, input bit rst, input bit we, input int wa,
                               input logic [DATA_W-1:0] wd, input int ra1, input int ra2);
    reset     = rst;
    wr_enable = we;
    wr_addr   = ADDR_W'(wa);
    wr_data   = wd;
    rs1_addr  = ADDR_W'(ra1);
    rs2_addr  = ADDR_W'(ra2);
    #1;
    obs_rs1   = rs1_data;
    obs_rs2   = rs2_data;
    obs_ready = ready;
    checkOutput({tag, "_ready"}, {{(DATA_W-1){1'b0}}, obs_ready}, {{(DATA_W-1){1'b0}}, model_ready});
    checkOutput({tag, "_rs1"}, obs_rs1, modelRead(ra1, rst, we, wa, wd));
    checkOutput({tag, "_rs2"}, obs_rs2, modelRead(ra2, rst, we, wa, wd));
    @(posedge clk);
    if (rst) begin
      model_ready   = 1'b0;
      model_cleared = 0;
    end else if (!model_ready) begin
      model_cleared++;
      model_regs[model_cleared] = '0;
      if (model_cleared == NUM_REGS - 1) model_ready = 1'b1;
    end else if (we && wa != 0) begin
      model_regs[wa] = wd;
    end
    @(negedge clk);
  endtask

  // Release reset and count mid-cycle samples with ready low; a write is offered at drop_at.
  task automatic runInit(input string tag, input int drop_at);
    int zeros;
    zeros = 0;
    for (int i = 0; i < 40; i++) begin
      applyStimulus(tag, 1'b0, (i == drop_at), 7, 32'hA5A5_A5A5,
                    int'($urandom_range(0, NUM_REGS-1)), int'($urandom_range(0, NUM_REGS-1)));
      if (obs_ready) break;
      zeros++;
    end
    checkOutput({tag, "_ready_latency"}, DATA_W'(zeros), DATA_W'(NUM_REGS - 1));
  endtask

  initial begin
    logic [DATA_W-1:0] same_cycle;
    for (int r = 0; r < NUM_REGS; r++) model_regs[r] = '0;
    model_ready   = 1'b0;
    model_cleared = 0;

    reset = 1'b1; wr_enable = 1'b0; wr_addr = '0; wr_data = '0; rs1_addr = '0; rs2_addr = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Reset state, then the full init pass and a sweep of every register.
    applyStimulus("rst", 1'b1, 1'b1, 4, 32'h1111_1111, 0, 4);
    runInit("init1", -1);
    for (int a = 0; a < NUM_REGS; a++)
      applyStimulus("sweep", 1'b0, 1'b0, 0, '0, a, NUM_REGS - 1 - a);

    // Basic write, then a dropped x0 write.
    applyStimulus("wr_x5", 1'b0, 1'b1, 5, 32'hDEAD_BEEF, 0, 0);
    applyStimulus("wr_x0", 1'b0, 1'b1, 0, 32'h0000_1234, 5, 0);
    checkOutput("x5_read", obs_rs1, 32'hDEAD_BEEF);
    applyStimulus("rd_x0", 1'b0, 1'b0, 0, '0, 5, 0);
    checkOutput("x0_read", obs_rs2, 32'h0);

    // Same-cycle write and dual read of x9.
    applyStimulus("wr_x9_old", 1'b0, 1'b1, 9, 32'h0000_0011, 0, 0);
    applyStimulus("wr_x9_new", 1'b0, 1'b1, 9, 32'h0F0F_0F0F, 9, 9);
`ifdef REGFILE_BYPASS_EN
    same_cycle = 32'h0F0F_0F0F;
`else
    same_cycle = 32'h0000_0011;
`endif
    checkOutput("x9_same_rs1", obs_rs1, same_cycle);
    checkOutput("x9_same_rs2", obs_rs2, same_cycle);
    applyStimulus("rd_x9", 1'b0, 1'b0, 0, '0, 9, 9);
    checkOutput("x9_next_rs1", obs_rs1, 32'h0F0F_0F0F);
    checkOutput("x9_next_rs2", obs_rs2, 32'h0F0F_0F0F);

    // Reset in RUN, then abort the init pass at edge 15 and restart it.
    applyStimulus("wr_x3", 1'b0, 1'b1, 3, 32'h0000_0055, 3, 0);
    applyStimulus("rst2", 1'b1, 1'b0, 0, '0, 3, 3);
    for (int i = 0; i < 14; i++)
      applyStimulus("init2", 1'b0, 1'b0, 0, '0, 3, 0);
    applyStimulus("rst3", 1'b1, 1'b0, 0, '0, 3, 0);
    runInit("init3", -1);
    applyStimulus("rd_x3", 1'b0, 1'b0, 0, '0, 3, 3);
    checkOutput("x3_cleared", obs_rs1, 32'h0);

    // Write offered at init edge 10 must be dropped.
    applyStimulus("rst4", 1'b1, 1'b0, 0, '0, 0, 0);
    runInit("init4", 9);
    applyStimulus("rd_x7", 1'b0, 1'b0, 0, '0, 7, 7);
    checkOutput("x7_dropped", obs_rs1, 32'h0);

    // Random RUN traffic, reads biased toward the write address.
    for (int c = 0; c < 2000; c++) begin
      int wa, ra1, ra2;
      wa  = int'($urandom_range(0, NUM_REGS-1));
      ra1 = ($urandom_range(0, 3) == 0) ? wa : int'($urandom_range(0, NUM_REGS-1));
      ra2 = ($urandom_range(0, 3) == 0) ? wa : int'($urandom_range(0, NUM_REGS-1));
      applyStimulus("rand", 1'b0, 1'($urandom_range(0, 1)), wa, $urandom, ra1, ra2);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
